// File: rtl/key_unlock_pkg.sv
// rtl/key_unlock_pkg.sv - constants, unlock address table and state encoding for key_unlock_seq
package key_unlock_pkg;

  localparam int UNLOCK_LEN = 6;
  localparam logic [3:0] UNLOCK_SEQ [UNLOCK_LEN] = '{4'h2, 4'hA, 4'hB, 4'h9, 4'h2, 4'hA};
  localparam logic [3:0] READ_ADDR = 4'h0;
  localparam logic [15:0] EXPECTED_KEY = 16'h00B2;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, DONE} state_t;
  typedef enum logic {PH_UNLOCK, PH_READ} phase_t;

  // Table lookup by compare so an out-of-range index reads as zero.
  function automatic logic [3:0] unlock_addr(input logic [4:0] idx);
    unlock_addr = 4'h0;
    for (int i = 0; i < UNLOCK_LEN; i++) begin
      if (idx == 5'(i)) unlock_addr = UNLOCK_SEQ[i];
    end
  endfunction

endpackage

// File: rtl/key_unlock_seq.sv
// rtl/key_unlock_seq.sv - serial key device unlock-then-read sequencer
// Optional key comparator output enabled by KEY_UNLOCK_CHECK_EN.
module key_unlock_seq
  import key_unlock_pkg::*;
#(
  parameter int READ_BITS  = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        sdrd,
  output logic        ba13,
  output logic        ba12,
  output logic [3:0]  ba_lo,
  output logic        br_w,
  output logic        sser_n,
  output logic        busy,
  output logic        done,
`ifdef KEY_UNLOCK_CHECK_EN
  output logic        key_match,
`endif
  output logic [15:0] key_data
);

  localparam logic [4:0] UNLOCK_LAST = 5'(UNLOCK_LEN - 1);
  localparam logic [4:0] READ_LAST   = 5'(READ_BITS - 1);
  localparam logic [1:0] GAP_LAST    = 2'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t      state, state_nx;
  phase_t      phase;
  logic [4:0]  index;
  logic [1:0]  gap_cnt;
  logic [15:0] key_nx;
  logic        access_end;
  logic        last_access;
  logic        accept;

  assign accept      = (state == IDLE) && start && !abort;
  assign last_access = (phase == PH_UNLOCK) ? (index == UNLOCK_LAST) : (index == READ_LAST);
  assign access_end  = ((state == STROBE) && (GAP_CYCLES == 0)) ||
                       ((state == GAP) && (gap_cnt == GAP_LAST));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE: begin
        if (GAP_CYCLES != 0)                     state_nx = GAP;
        else if (last_access && phase == PH_READ) state_nx = DONE;
        else                                     state_nx = SETUP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST)
          state_nx = (last_access && phase == PH_READ) ? DONE : SETUP;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // Bus drive: idle values unless an access is in flight.
  always_comb begin
    ba13   = 1'b1;
    ba12   = 1'b0;
    ba_lo  = 4'h0;
    br_w   = 1'b0;
    sser_n = 1'b1;
    busy   = 1'b0;
    done   = (state == DONE);
    if (state == SETUP || state == STROBE || state == GAP) begin
      ba13   = 1'b0;
      ba12   = 1'b1;
      br_w   = 1'b1;
      ba_lo  = (phase == PH_UNLOCK) ? unlock_addr(index) : READ_ADDR;
      sser_n = (state != STROBE);
      busy   = 1'b1;
    end
  end

  // Abort suppresses the sdrd sample that would end a read strobe.
  always_comb begin
    key_nx = key_data;
    if (!abort) begin
      if (state == STROBE && phase == PH_READ) key_nx = {key_data[14:0], sdrd};
      if (access_end && phase == PH_UNLOCK && last_access) key_nx = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= PH_UNLOCK;
      index    <= 5'd0;
      gap_cnt  <= 2'd0;
      key_data <= 16'h0000;
    end else begin
      state    <= state_nx;
      key_data <= key_nx;
      if (accept) begin
        phase   <= PH_UNLOCK;
        index   <= 5'd0;
        gap_cnt <= 2'd0;
      end else if (!abort) begin
        if (state == STROBE)   gap_cnt <= 2'd0;
        else if (state == GAP) gap_cnt <= gap_cnt + 2'd1;
        if (access_end) begin
          if (phase == PH_UNLOCK && last_access) begin
            phase <= PH_READ;
            index <= 5'd0;
          end else if (index != 5'h1f) begin
            index <= index + 5'd1;
          end
        end
      end
    end
  end

`ifdef KEY_UNLOCK_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n || accept)                   key_match <= 1'b0;
    else if (state_nx == DONE && state != DONE) key_match <= (key_nx == EXPECTED_KEY);
  end
`endif

endmodule

// File: tb/tb_key_unlock_seq.sv
// tb/tb_key_unlock_seq.sv - scoreboard bench for key_unlock_seq
// Also covers the key_match output when KEY_UNLOCK_CHECK_EN is defined.
module tb_key_unlock_seq;

  localparam logic [15:0] GOLDEN_KEY = 16'h00B2;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, sdrd;
  logic        ba13, ba12, br_w, sser_n, busy, done;
  logic [3:0]  ba_lo;
  logic [15:0] key_data;
`ifdef KEY_UNLOCK_CHECK_EN
  logic        key_match;
`endif

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [3:0]  addr_q[$];
  logic [15:0] exp_key_q[$];

  always #5 clk = ~clk;

  key_unlock_seq #(.READ_BITS(8), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sdrd(sdrd),
    .ba13(ba13), .ba12(ba12), .ba_lo(ba_lo), .br_w(br_w), .sser_n(sser_n),
    .busy(busy), .done(done),
`ifdef KEY_UNLOCK_CHECK_EN
    .key_match(key_match),
`endif
    .key_data(key_data)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: strobe addresses and finished keys popped as the DUT emits them.
  always @(negedge clk) begin
    if (rst_n && !sser_n) begin
      chk("strobe_pending", 16'(addr_q.size() != 0), 16'd1);
      if (addr_q.size() != 0) chk("strobe_ba_lo", 16'(ba_lo), 16'(addr_q.pop_front()));
      chk("strobe_bus", 16'({ba13, ba12, br_w}), 16'(3'b011));
    end
    if (rst_n && done) begin
      done_cnt++;
      chk("done_pending", 16'(exp_key_q.size() != 0), 16'd1);
      if (exp_key_q.size() != 0) begin
        logic [15:0] e;
        e = exp_key_q.pop_front();
        chk("key_data", key_data, e);
`ifdef KEY_UNLOCK_CHECK_EN
        chk("key_match", 16'(key_match), 16'(e == GOLDEN_KEY));
`endif
      end
    end
  end

  // mode 0 normal, 1 abort at strobe stop_at, 2 reset at strobe stop_at, 3 start held while busy
  task automatic run(input logic [7:0] bits, input int mode, input int stop_at);
    int n, strobes, d0;
    logic [15:0] k0;
    logic stopped;
    logic [3:0] seq [6];
    seq = '{4'h2, 4'hA, 4'hB, 4'h9, 4'h2, 4'hA};
    foreach (seq[i]) addr_q.push_back(seq[i]);
    for (int i = 0; i < 8; i++) addr_q.push_back(4'h0);
    if (mode == 0 || mode == 3) exp_key_q.push_back({8'h00, bits});
    d0 = done_cnt;
    k0 = key_data;
    strobes = 0;
    stopped = 1'b0;
    start = 1'b1;
    tick();
    if (mode != 3) start = 1'b0;
    n = 1;
    chk("busy_after_start", 16'(busy), 16'd1);
    while (n < 200 && !done && !stopped) begin
      if (!sser_n) begin
        strobes++;
        if (strobes > 6) sdrd = bits[14 - strobes];
        if (strobes == stop_at) begin
          if (mode == 1) abort = 1'b1;
          else if (mode == 2) rst_n = 1'b0;
          stopped = 1'b1;
        end
      end
      tick();
      n++;
      abort = 1'b0;
      rst_n = 1'b1;
    end
    if (mode == 0 || mode == 3) begin
      chk("run_done_seen", 16'(done), 16'd1);
      chk("latency", 16'(n), 16'd43);
      chk("strobe_count", 16'(strobes), 16'd14);
      chk("busy_in_done", 16'(busy), 16'd0);
      start = 1'b0;
      tick();
      chk("done_one_cycle", 16'(done), 16'd0);
      chk("key_hold", key_data, {8'h00, bits});
      repeat (5) tick();
      chk("done_pulses", 16'(done_cnt - d0), 16'd1);
      chk("idle_after_run", 16'({busy, sser_n, ba13}), 16'(3'b011));
    end else if (mode == 1) begin
      chk("abort_sser_n", 16'(sser_n), 16'd1);
      chk("abort_busy", 16'(busy), 16'd0);
      chk("abort_ba13", 16'(ba13), 16'd1);
      chk("abort_key", key_data, k0);
      repeat (60) tick();
      chk("abort_no_done", 16'(done_cnt - d0), 16'd0);
      addr_q.delete();
    end else begin
      chk("reset_busy", 16'(busy), 16'd0);
      chk("reset_key", key_data, 16'h0000);
      chk("reset_sser_n", 16'(sser_n), 16'd1);
      repeat (60) tick();
      chk("reset_no_done", 16'(done_cnt - d0), 16'd0);
      addr_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sdrd = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_bus", 16'({sser_n, ba13, ba12, br_w, ba_lo}), 16'(8'b1100_0000));
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_key", key_data, 16'h0000);

    run(8'b1011_0010, 0, 0);
    run(8'h00, 1, 3);
    run(8'h5C, 3, 0);
    run(8'hFF, 2, 9);
    run(8'h01, 0, 0);
    run(8'h80, 0, 0);

    chk("addr_q_drained", 16'(addr_q.size()), 16'd0);
    chk("key_q_drained", 16'(exp_key_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
